// File: rtl/mii_frame_monitor_if.sv
// MII TX tap bundle: word qualifier, data lanes and per-lane control bits.
// The monitor only ever listens on this bundle (slave); whoever drives the
// MII bus owns the master side.
interface mii_frame_monitor_if #(
    parameter int DATA_WIDTH = 64
) ();
    localparam int CTRL_WIDTH = DATA_WIDTH / 8;

    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic [CTRL_WIDTH-1:0] i_tx_ctrl;

    modport master (
        output i_valid,
        output i_tx_data,
        output i_tx_ctrl
    );

    modport slave (
        input i_valid,
        input i_tx_data,
        input i_tx_ctrl
    );
endinterface

// File: rtl/mii_frame_monitor.sv
// Lane-aware TX frame monitor for the MII datapath.
// Follows START/TERMINATE control characters, counts payload bytes, flags
// short/long/protocol errors and keeps saturating frame/error statistics.
// Passive: it only observes the bus.
// Optional build macro MII_MON_IDLE_CHECK_EN: also police IDLE-state words
// (data lanes or unexpected control characters raise a protocol error).
module mii_frame_monitor #(
    parameter int         DATA_WIDTH        = 64,
    parameter int         CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter logic [7:0] IDLE_CODE         = 8'h07,
    parameter logic [7:0] START_CODE        = 8'hFB,
    parameter logic [7:0] TERM_CODE         = 8'hFD,
    parameter int         MIN_PAYLOAD_BYTES = 40,
    parameter int         MAX_PAYLOAD_BYTES = 136,
    parameter int         CNT_WIDTH         = 16
) (
    input  logic                 clk,
    input  logic                 i_rst,
    mii_frame_monitor_if.slave   mii,
    input  logic                 i_clear_stats,
    output logic                 o_frame_done,
    output logic [CNT_WIDTH-1:0] o_frame_len,
    output logic                 o_err_short,
    output logic                 o_err_long,
    output logic                 o_err_proto,
    output logic [CNT_WIDTH-1:0] o_frame_cnt,
    output logic [CNT_WIDTH-1:0] o_err_cnt
);
    localparam int LANES = CTRL_WIDTH;

`ifdef MII_MON_IDLE_CHECK_EN
    localparam bit IDLE_CHECK_EN = 1'b1;
`else
    localparam bit IDLE_CHECK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_DRAIN
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic [CNT_WIDTH-1:0] frame_len_q, frame_len_d;
    logic                 err_short_q, err_short_d;
    logic                 err_long_q, err_long_d;
    logic                 err_proto_q, err_proto_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic [CTRL_WIDTH-1:0] scan_ctrl;
    logic                  scan_found;
    int                    scan_k;
    logic [7:0]            scan_byte;
    logic                  any_term;
    logic                  idle_bad;
    logic                  start_word;
    logic [CNT_WIDTH-1:0]  lane_bytes;
    logic [CNT_WIDTH-1:0]  len_sum;

    // Lane decode: lowest control lane (lane 0 excluded for a START word), any TERM, idle legality
    always_comb begin
        scan_ctrl = mii.i_tx_ctrl;
        if (state_q == ST_IDLE) begin
            scan_ctrl[0] = 1'b0;
        end
        scan_found = 1'b0;
        scan_k     = 0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (scan_ctrl[k]) begin
                scan_found = 1'b1;
                scan_k     = k;
            end
        end
        scan_byte = mii.i_tx_data[8*scan_k +: 8];

        any_term = 1'b0;
        idle_bad = ~(&mii.i_tx_ctrl);
        for (int k = 0; k < LANES; k++) begin
            if (mii.i_tx_ctrl[k] && (mii.i_tx_data[8*k +: 8] == TERM_CODE)) begin
                any_term = 1'b1;
            end
            if (mii.i_tx_ctrl[k] && (mii.i_tx_data[8*k +: 8] != IDLE_CODE)) begin
                idle_bad = 1'b1;
            end
        end

        start_word = mii.i_tx_ctrl[0] && (mii.i_tx_data[7:0] == START_CODE);

        // In the START word lane 0 is the START itself, so payload begins at lane 1
        if (state_q == ST_IDLE) begin
            lane_bytes = scan_found ? CNT_WIDTH'(scan_k - 1) : CNT_WIDTH'(LANES - 1);
            len_sum    = lane_bytes;
        end else begin
            lane_bytes = scan_found ? CNT_WIDTH'(scan_k) : CNT_WIDTH'(LANES);
            len_sum    = sat_add(cnt_q, lane_bytes);
        end
    end

    // Next state, byte counter and per-word pulse decisions
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        err_short_d  = 1'b0;
        err_long_d   = 1'b0;
        err_proto_d  = 1'b0;

        if (mii.i_valid) begin
            case (state_q)
                ST_DRAIN: begin
                    if (any_term) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    if ((state_q == ST_DATA) || start_word) begin
                        if (!scan_found) begin
                            state_d = ST_DATA;
                            cnt_d   = len_sum;
                        end else if (scan_byte == TERM_CODE) begin
                            state_d      = ST_IDLE;
                            cnt_d        = '0;
                            frame_done_d = 1'b1;
                            frame_len_d  = len_sum;
                            err_short_d  = len_sum < CNT_WIDTH'(MIN_PAYLOAD_BYTES);
                            err_long_d   = len_sum > CNT_WIDTH'(MAX_PAYLOAD_BYTES);
                        end else begin
                            state_d     = ST_DRAIN;
                            cnt_d       = '0;
                            err_proto_d = 1'b1;
                        end
                    end else begin
                        err_proto_d = IDLE_CHECK_EN & idle_bad;
                    end
                end
            endcase
        end
    end

    // Statistics: counted alongside the pulses they describe; clear has priority
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (i_clear_stats) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end else begin
            if (frame_done_d) begin
                frame_cnt_d = sat_inc(frame_cnt_q);
            end
            if (err_short_d || err_long_d || err_proto_d) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end
    end

    // State, counters and registered outputs; reset discards any frame in flight
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            err_proto_q  <= 1'b0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            err_proto_q  <= err_proto_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_frame_done = frame_done_q;
    assign o_frame_len  = frame_len_q;
    assign o_err_short  = err_short_q;
    assign o_err_long   = err_long_q;
    assign o_err_proto  = err_proto_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_mii_frame_monitor.sv
// Self-checking bench for mii_frame_monitor (DATA_WIDTH=64).
// Frames are described as a byte stream (START, payload, TERMINATE, idle
// padding) and chopped into 8-lane words; expectations come from the payload
// length alone.
module tb_mii_frame_monitor;
    localparam int CW = 16;

`ifdef MII_MON_IDLE_CHECK_EN
    localparam bit IDLE_CHK = 1'b1;
`else
    localparam bit IDLE_CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          o_frame_done;
    logic [CW-1:0] o_frame_len;
    logic          o_err_short;
    logic          o_err_long;
    logic          o_err_proto;
    logic [CW-1:0] o_frame_cnt;
    logic [CW-1:0] o_err_cnt;

    mii_frame_monitor_if #(.DATA_WIDTH(64)) bus ();

    mii_frame_monitor dut (
        .clk          (clk),
        .i_rst        (rst),
        .mii          (bus),
        .i_clear_stats(clr),
        .o_frame_done (o_frame_done),
        .o_frame_len  (o_frame_len),
        .o_err_short  (o_err_short),
        .o_err_long   (o_err_long),
        .o_err_proto  (o_err_proto),
        .o_frame_cnt  (o_frame_cnt),
        .o_err_cnt    (o_err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          exp_fcnt = 0;
    int          exp_ecnt = 0;
    logic [15:0] e_len;
    logic        e_short, e_long;
    logic [15:0] last_len = '0;

    // values captured at the end of a frame
    int          c_early;
    logic        c_done, c_short, c_long, c_proto;
    logic [15:0] c_len, c_fcnt, c_ecnt;

    task automatic step(input bit v, input logic [63:0] d, input logic [7:0] c, input bit clear);
        bus.i_valid   = v;
        bus.i_tx_data = d;
        bus.i_tx_ctrl = c;
        clr           = clear;
        @(posedge clk);
        #1;
    endtask

    task automatic stall_word();
        step(1'b0, {$urandom, $urandom}, 8'($urandom), 1'b0);
    endtask

    task automatic idle_word();
        step(1'b1, {8{8'h07}}, 8'hFF, 1'b0);
    endtask

    // stall_mode: 0 none, 1 random stalls, 2 three stalled cycles before word 3
    task automatic send_frame(input int L, input int stall_mode, input bit clr_last);
        logic [8:0]  q[$];
        logic [63:0] d;
        logic [7:0]  c;
        int          nw;
        q.push_back({1'b1, 8'hFB});
        for (int i = 0; i < L; i++) q.push_back({1'b0, 8'($urandom)});
        q.push_back({1'b1, 8'hFD});
        while ((q.size() % 8) != 0) q.push_back({1'b1, 8'h07});
        nw = q.size() / 8;
        c_early = 0;
        for (int w = 0; w < nw; w++) begin
            for (int l = 0; l < 8; l++) begin
                d[8*l +: 8] = q[w*8+l][7:0];
                c[l]        = q[w*8+l][8];
            end
            if (stall_mode == 2 && w == 3) repeat (3) stall_word();
            if (stall_mode == 1 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) stall_word();
            step(1'b1, d, c, clr_last && (w == nw - 1));
            if (w < nw - 1 && (o_frame_done || o_err_proto || o_err_short || o_err_long)) c_early++;
        end
        c_done  = o_frame_done;  c_short = o_err_short; c_long = o_err_long;
        c_proto = o_err_proto;   c_len   = o_frame_len;
        c_fcnt  = o_frame_cnt;   c_ecnt  = o_err_cnt;
    endtask

    // expected result of one clean frame of L payload bytes
    task automatic model_frame(input int L, input bit clear);
        e_len    = (L > 65535) ? 16'hFFFF : 16'(L);
        e_short  = e_len < 16'd40;
        e_long   = e_len > 16'd136;
        last_len = e_len;
        if (clear) begin
            exp_fcnt = 0;
            exp_ecnt = 0;
        end else begin
            if (exp_fcnt < 65535) exp_fcnt++;
            if ((e_short || e_long) && exp_ecnt < 65535) exp_ecnt++;
        end
    endtask

    task automatic test_reset();
        bus.i_valid = 1'b1; bus.i_tx_data = {8{8'h07}} | 64'hFB; bus.i_tx_ctrl = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({o_frame_done, o_err_short, o_err_long, o_err_proto, o_frame_len, o_frame_cnt, o_err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got done=%b s=%b l=%b p=%b len=%0d fc=%0d ec=%0d, want all 0",
                     o_frame_done, o_err_short, o_err_long, o_err_proto, o_frame_len, o_frame_cnt, o_err_cnt);
        end
        rst = 1'b0;
        idle_word();
        n_tests++;
        if ({o_frame_done, o_err_proto} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got done=%b proto=%b, want 0 0", o_frame_done, o_err_proto);
        end
    endtask

    task automatic test_length_range();
        int lens[6] = '{50, 31, 147, 3, 0, 40};
        foreach (lens[i]) begin
            send_frame(lens[i], 0, 1'b0);
            model_frame(lens[i], 1'b0);
            n_tests++;
            if ({c_done, c_proto, c_short, c_long} !== {1'b1, 1'b0, e_short, e_long}) begin
                n_fail++;
                $display("FAIL len%0d_flags: got done/proto/short/long=%b%b%b%b want 1%b%b%b",
                         lens[i], c_done, c_proto, c_short, c_long, 1'b0, e_short, e_long);
            end
            n_tests++;
            if (c_len !== e_len) begin
                n_fail++;
                $display("FAIL len%0d_value: got %0d want %0d", lens[i], c_len, e_len);
            end
            n_tests++;
            if (c_fcnt !== 16'(exp_fcnt) || c_ecnt !== 16'(exp_ecnt) || c_early != 0) begin
                n_fail++;
                $display("FAIL len%0d_stats: got fc=%0d ec=%0d early=%0d want fc=%0d ec=%0d early=0",
                         lens[i], c_fcnt, c_ecnt, c_early, exp_fcnt, exp_ecnt);
            end
            idle_word();
            n_tests++;
            if (o_frame_done !== 1'b0 || o_frame_len !== e_len) begin
                n_fail++;
                $display("FAIL len%0d_hold: got done=%b len=%0d want done=0 len=%0d",
                         lens[i], o_frame_done, o_frame_len, e_len);
            end
        end
    endtask

    task automatic test_stall();
        send_frame(50, 2, 1'b0);
        model_frame(50, 1'b0);
        n_tests++;
        if (c_done !== 1'b1 || c_len !== 16'd50 || c_early != 0 || c_fcnt !== 16'(exp_fcnt)) begin
            n_fail++;
            $display("FAIL stall_len: got done=%b len=%0d early=%0d fc=%0d want 1 50 0 %0d",
                     c_done, c_len, c_early, c_fcnt, exp_fcnt);
        end
    endtask

    task automatic test_proto();
        logic [63:0] d;
        step(1'b1, {{7{8'($urandom)}}, 8'hFB}, 8'h01, 1'b0);
        step(1'b1, {$urandom, $urandom}, 8'h00, 1'b0);
        step(1'b1, {$urandom, $urandom}, 8'h00, 1'b0);
        d = {$urandom, $urandom};
        d[23:16] = 8'hFB;
        step(1'b1, d, 8'h04, 1'b0);
        if (exp_ecnt < 65535) exp_ecnt++;
        n_tests++;
        if ({o_err_proto, o_frame_done} !== 2'b10 || o_err_cnt !== 16'(exp_ecnt)) begin
            n_fail++;
            $display("FAIL proto_pulse: got proto=%b done=%b ec=%0d want 1 0 %0d",
                     o_err_proto, o_frame_done, o_err_cnt, exp_ecnt);
        end
        step(1'b1, {$urandom, $urandom}, 8'h00, 1'b0);
        d = {{2{8'h07}}, 8'hFD, 40'($urandom)};
        step(1'b1, d, 8'hE0, 1'b0);
        n_tests++;
        if ({o_err_proto, o_frame_done} !== 2'b00 || o_frame_cnt !== 16'(exp_fcnt) || o_frame_len !== last_len) begin
            n_fail++;
            $display("FAIL proto_drain: got proto=%b done=%b fc=%0d len=%0d want 0 0 %0d %0d",
                     o_err_proto, o_frame_done, o_frame_cnt, o_frame_len, exp_fcnt, last_len);
        end
        idle_word();
    endtask

    task automatic test_clear_same_cycle();
        send_frame(50, 0, 1'b1);
        model_frame(50, 1'b1);
        n_tests++;
        if (c_done !== 1'b1 || c_fcnt !== 16'd0 || c_ecnt !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_done: got done=%b fc=%0d ec=%0d want 1 0 0", c_done, c_fcnt, c_ecnt);
        end
        send_frame(20, 0, 1'b1);
        model_frame(20, 1'b1);
        n_tests++;
        if (c_short !== 1'b1 || c_fcnt !== 16'd0 || c_ecnt !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_err: got short=%b fc=%0d ec=%0d want 1 0 0", c_short, c_fcnt, c_ecnt);
        end
        idle_word();
    endtask

    task automatic test_saturation();
        send_frame(66000, 0, 1'b0);
        model_frame(66000, 1'b0);
        n_tests++;
        if (c_done !== 1'b1 || c_len !== 16'hFFFF || c_long !== 1'b1 || c_ecnt !== 16'(exp_ecnt)) begin
            n_fail++;
            $display("FAIL sat_len: got done=%b len=%0d long=%b ec=%0d want 1 65535 1 %0d",
                     c_done, c_len, c_long, c_ecnt, exp_ecnt);
        end
        idle_word();
    endtask

    task automatic test_idle_check();
        idle_word();
        n_tests++;
        if (o_err_proto !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_clean: got proto=%b want 0", o_err_proto);
        end
        step(1'b1, 64'h0707_9C07_0707_0707, 8'hFF, 1'b0);
        if (IDLE_CHK && exp_ecnt < 65535) exp_ecnt++;
        n_tests++;
        if (o_err_proto !== IDLE_CHK || o_err_cnt !== 16'(exp_ecnt)) begin
            n_fail++;
            $display("FAIL idle_bad_ctrl: got proto=%b ec=%0d want %b %0d", o_err_proto, o_err_cnt, IDLE_CHK, exp_ecnt);
        end
        idle_word();
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            int L;
            L = $urandom_range(0, 200);
            send_frame(L, 1, 1'b0);
            model_frame(L, 1'b0);
            n_tests++;
            if ({c_done, c_proto, c_short, c_long} !== {1'b1, 1'b0, e_short, e_long} || c_len !== e_len
                || c_fcnt !== 16'(exp_fcnt) || c_ecnt !== 16'(exp_ecnt) || c_early != 0) begin
                n_fail++;
                $display("FAIL rand%0d_L%0d: got d/p/s/l=%b%b%b%b len=%0d fc=%0d ec=%0d early=%0d want 10%b%b len=%0d fc=%0d ec=%0d",
                         f, L, c_done, c_proto, c_short, c_long, c_len, c_fcnt, c_ecnt, c_early,
                         e_short, e_long, e_len, exp_fcnt, exp_ecnt);
            end
            repeat ($urandom_range(0, 2)) idle_word();
        end
    endtask

    task automatic test_reset_midframe();
        step(1'b1, {{7{8'h55}}, 8'hFB}, 8'h01, 1'b0);
        step(1'b1, {$urandom, $urandom}, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({o_frame_done, o_err_short, o_err_long, o_err_proto, o_frame_len, o_frame_cnt, o_err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got len=%0d fc=%0d ec=%0d done=%b want all 0",
                     o_frame_len, o_frame_cnt, o_err_cnt, o_frame_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_fcnt = 0;
        exp_ecnt = 0;
        step(1'b1, {{7{8'h07}}, 8'hFD}, 8'hFF, 1'b0);
        if (IDLE_CHK) exp_ecnt++;
        n_tests++;
        if (o_frame_done !== 1'b0 || o_err_proto !== IDLE_CHK || o_err_cnt !== 16'(exp_ecnt)) begin
            n_fail++;
            $display("FAIL rst_idle_after: got done=%b proto=%b ec=%0d want 0 %b %0d",
                     o_frame_done, o_err_proto, o_err_cnt, IDLE_CHK, exp_ecnt);
        end
        send_frame(60, 0, 1'b0);
        model_frame(60, 1'b0);
        n_tests++;
        if (c_done !== 1'b1 || c_len !== 16'd60 || c_fcnt !== 16'(exp_fcnt)) begin
            n_fail++;
            $display("FAIL rst_recover: got done=%b len=%0d fc=%0d want 1 60 %0d", c_done, c_len, c_fcnt, exp_fcnt);
        end
    endtask

    initial begin
        test_reset();
        test_length_range();
        test_stall();
        test_proto();
        test_clear_same_cycle();
        test_saturation();
        test_idle_check();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
